// File: rtl/ctrl_soc.sv
// ctrl_soc: hardwired board controller. After reset it wakes the SPI flash,
// reads NBYTES from FLASH_ADDR, sends them on the UART, then waits in DONE
// until btn1 requests a restart. The ML accelerator QSPI port is held idle.
module ctrl_soc #(
  parameter logic [23:0] FLASH_ADDR = 24'h100000,
  parameter int unsigned NBYTES     = 6,
  parameter int unsigned BAUD_DIV   = 12,
  parameter int unsigned CS_GAP     = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic ser_rx,
  output logic ser_tx,
  output logic flash_clk,
  output logic flash_csb,
  inout  logic flash_io0,
  inout  logic flash_io1,
  inout  logic flash_io2,
  inout  logic flash_io3,
  output logic ledr_n,
  output logic ledg_n,
  output logic led1,
  output logic led2,
  output logic led3,
  output logic led4,
  output logic led5,
  input  logic btn1,
  input  logic btn2,
  input  logic btn3,
  output logic ml_clk,
  output logic ml_csb,
  inout  logic ml_io0,
  inout  logic ml_io1,
  inout  logic ml_io2,
  inout  logic ml_io3,
  input  logic ml_irq,
  input  logic ml_err
);

  localparam logic [2:0] ST_WAKE = 3'd0;
  localparam logic [2:0] ST_GAP  = 3'd1;
  localparam logic [2:0] ST_READ = 3'd2;
  localparam logic [2:0] ST_TX   = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [31:0] WAKE_WORD = {8'hAB, 24'h000000};
  localparam logic [31:0] READ_WORD = {8'h03, FLASH_ADDR};
  localparam logic [7:0]  WAKE_LAST = 8'd7;
  localparam logic [7:0]  READ_LAST = 8'(32 + 8 * NBYTES - 1);
  localparam logic [7:0]  GAP_LAST  = 8'(CS_GAP - 1);
  localparam logic [7:0]  BAUD_LAST = 8'(BAUD_DIV - 1);
  localparam logic [3:0]  LAST_BYTE = 4'(NBYTES - 1);

  logic [2:0]  state;
  logic        run_q;
  logic        csb_q, sclk_q, mosi_q, tx_q;
  logic [30:0] sh_out;
  logic [7:0]  bit_num;
  logic [6:0]  rx_sh;
  logic [7:0]  byte_buf [0:15];
  logic [7:0]  gap_cnt;
  logic [7:0]  baud_cnt;
  logic [3:0]  tx_bit;
  logic [3:0]  byte_idx;
  logic [3:0]  data_idx;
  logic        btn_s1, btn_s2, btn_d;
  logic        irq_s1, irq_s2, err_s1, err_s2;
  logic        btn_rise;
  logic        unused_inputs;

  // Data bits start at bit_num 32, so the byte index is bit_num/8 - 4 (mod 16).
  assign data_idx = bit_num[6:3] - 4'd4;
  assign btn_rise = btn_s2 & ~btn_d;
  assign unused_inputs = ^{ser_rx, btn2, btn3};

  // Double-flop synchronizers for the asynchronous button and accelerator status.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_s1 <= 1'b0; btn_s2 <= 1'b0; btn_d <= 1'b0;
      irq_s1 <= 1'b0; irq_s2 <= 1'b0;
      err_s1 <= 1'b0; err_s2 <= 1'b0;
      run_q  <= 1'b0;
    end else begin
      btn_s1 <= btn1;   btn_s2 <= btn_s1; btn_d <= btn_s2;
      irq_s1 <= ml_irq; irq_s2 <= irq_s1;
      err_s1 <= ml_err; err_s2 <= err_s1;
      run_q  <= 1'b1;
    end
  end

  // Main sequencer: flash wake, gap, read, UART transmit, done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_WAKE;
      csb_q    <= 1'b1;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      tx_q     <= 1'b1;
      sh_out   <= '0;
      bit_num  <= '0;
      rx_sh    <= '0;
      gap_cnt  <= '0;
      baud_cnt <= '0;
      tx_bit   <= '0;
      byte_idx <= '0;
      for (int unsigned i = 0; i < 16; i++) byte_buf[i] <= '0;
    end else begin
      case (state)
        ST_WAKE: begin
          if (csb_q) begin
            csb_q   <= 1'b0;
            sclk_q  <= 1'b0;
            sh_out  <= WAKE_WORD[30:0];
            mosi_q  <= WAKE_WORD[31];
            bit_num <= '0;
          end else if (!sclk_q) begin
            sclk_q <= 1'b1;
          end else if (bit_num == WAKE_LAST) begin
            csb_q   <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            gap_cnt <= '0;
            state   <= ST_GAP;
          end else begin
            sclk_q  <= 1'b0;
            mosi_q  <= sh_out[30];
            sh_out  <= {sh_out[29:0], 1'b0};
            bit_num <= bit_num + 8'd1;
          end
        end
        ST_GAP: begin
          // The read starts on the last gap cycle so csb is high exactly CS_GAP cycles.
          if (gap_cnt == GAP_LAST) begin
            csb_q   <= 1'b0;
            sclk_q  <= 1'b0;
            sh_out  <= READ_WORD[30:0];
            mosi_q  <= READ_WORD[31];
            bit_num <= '0;
            state   <= ST_READ;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        ST_READ: begin
          if (!sclk_q) begin
            sclk_q <= 1'b1;
            if (bit_num >= 8'd32) begin
              rx_sh <= {rx_sh[5:0], flash_io1};
              if (bit_num[2:0] == 3'd7) byte_buf[data_idx] <= {rx_sh, flash_io1};
            end
          end else if (bit_num == READ_LAST) begin
            csb_q    <= 1'b1;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            tx_q     <= 1'b0;
            tx_bit   <= '0;
            byte_idx <= '0;
            baud_cnt <= '0;
            state    <= ST_TX;
          end else begin
            sclk_q  <= 1'b0;
            mosi_q  <= sh_out[30];
            sh_out  <= {sh_out[29:0], 1'b0};
            bit_num <= bit_num + 8'd1;
          end
        end
        ST_TX: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (tx_bit == 4'd9) begin
              if (byte_idx == LAST_BYTE) begin
                tx_q  <= 1'b1;
                state <= ST_DONE;
              end else begin
                byte_idx <= byte_idx + 4'd1;
                tx_bit   <= '0;
                tx_q     <= 1'b0;
              end
            end else begin
              tx_bit <= tx_bit + 4'd1;
              tx_q   <= (tx_bit == 4'd8) ? 1'b1 : byte_buf[byte_idx][tx_bit[2:0]];
            end
          end else begin
            baud_cnt <= baud_cnt + 8'd1;
          end
        end
        ST_DONE: begin
          if (btn_rise) state <= ST_WAKE;
        end
        default: state <= ST_WAKE;
      endcase
    end
  end

  assign ser_tx    = tx_q;
  assign flash_csb = csb_q;
  assign flash_clk = sclk_q;
  assign flash_io0 = mosi_q;
  assign flash_io2 = 1'b1;
  assign flash_io3 = 1'b1;

  assign led1   = run_q & ((state == ST_WAKE) | (state == ST_GAP) | (state == ST_READ));
  assign led2   = run_q & (state == ST_TX);
  assign led3   = run_q & (state == ST_DONE);
  assign ledg_n = ~led3;
  assign led4   = irq_s2;
  assign led5   = err_s2;
  assign ledr_n = ~err_s2;

  assign ml_clk = 1'b0;
  assign ml_csb = 1'b1;
  assign ml_io0 = 1'b0;
  assign ml_io1 = 1'b0;
  assign ml_io2 = 1'b0;
  assign ml_io3 = 1'b0;

endmodule

// File: tb/tb_ctrl_soc.sv
// tb_ctrl_soc: flash slave model plus UART decoder; expected traffic is derived
// from the flash contents and the command/timing rules of the controller.
module tb_ctrl_soc;
  localparam int unsigned NB   = 6;
  localparam int unsigned BAUD = 12;
  localparam int unsigned GAP  = 4;
  localparam logic [23:0] ADDR = 24'h100000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ser_rx = 1'b1, btn1 = 1'b0, btn2 = 1'b0, btn3 = 1'b0;
  logic ml_irq = 1'b0, ml_err = 1'b0;
  logic ser_tx, flash_clk, flash_csb, ledr_n, ledg_n;
  logic led1, led2, led3, led4, led5, ml_clk, ml_csb;
  wire  flash_io0, flash_io1, flash_io2, flash_io3;
  wire  ml_io0, ml_io1, ml_io2, ml_io3;
  logic io1_drv = 1'b1;
  assign flash_io1 = io1_drv;

  always #5 clk = ~clk;

  ctrl_soc #(.FLASH_ADDR(ADDR), .NBYTES(NB), .BAUD_DIV(BAUD), .CS_GAP(GAP)) dut (
    .clk(clk), .reset(rst), .ser_rx(ser_rx), .ser_tx(ser_tx),
    .flash_clk(flash_clk), .flash_csb(flash_csb),
    .flash_io0(flash_io0), .flash_io1(flash_io1), .flash_io2(flash_io2), .flash_io3(flash_io3),
    .ledr_n(ledr_n), .ledg_n(ledg_n),
    .led1(led1), .led2(led2), .led3(led3), .led4(led4), .led5(led5),
    .btn1(btn1), .btn2(btn2), .btn3(btn3),
    .ml_clk(ml_clk), .ml_csb(ml_csb),
    .ml_io0(ml_io0), .ml_io1(ml_io1), .ml_io2(ml_io2), .ml_io3(ml_io3),
    .ml_irq(ml_irq), .ml_err(ml_err)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int unsigned cyc = 0;
  int unsigned static_err = 0;
  logic [7:0] mem [0:15];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Flash slave: records every csb-low transaction and serves read data on io1.
  logic        prev_csb = 1'b1, prev_sclk = 1'b0;
  int unsigned t_bits = 0, t_cyc = 0, hi_run = 0;
  logic [31:0] t_hdr = '0;
  logic [7:0]  tr_cmd [$];
  logic [23:0] tr_addr [$];
  int unsigned tr_bits [$], tr_cyc [$], tr_gap [$];

  always @(negedge clk) begin
    if (flash_io2 !== 1'b1 || flash_io3 !== 1'b1 || ml_csb !== 1'b1 || ml_clk !== 1'b0 ||
        {ml_io0, ml_io1, ml_io2, ml_io3} !== 4'b0000) static_err++;
    if (flash_csb) hi_run++;
    if (!flash_csb) begin
      if (prev_csb) begin
        tr_gap.push_back(hi_run);
        hi_run = 0; t_bits = 0; t_cyc = 0; t_hdr = '0;
      end
      t_cyc++;
      if (flash_clk && !prev_sclk) begin
        if (t_bits < 32) t_hdr = {t_hdr[30:0], flash_io0};
        t_bits++;
      end
      if (!flash_clk && prev_sclk && t_bits >= 32 && t_hdr[31:24] == 8'h03) begin
        int idx, off;
        idx = int'(t_bits) - 32;
        off = int'(t_hdr[23:0]) - int'(ADDR) + idx / 8;
        io1_drv = (off >= 0 && off < 16) ? mem[off][7 - (idx % 8)] : 1'b0;
      end
    end else if (!prev_csb) begin
      tr_cmd.push_back((t_bits >= 32) ? t_hdr[31:24] : t_hdr[7:0]);
      tr_addr.push_back(t_hdr[23:0]);
      tr_bits.push_back(t_bits);
      tr_cyc.push_back(t_cyc);
      io1_drv = 1'b1;
    end
    prev_csb  = flash_csb;
    prev_sclk = flash_clk;
  end

  // UART 8N1 decoder sampling mid-bit.
  logic        u_busy = 1'b0, u_prev = 1'b1, u_seen = 1'b0;
  int unsigned u_cnt = 0, frame_err = 0, first_start = 0;
  logic [7:0]  u_byte = '0;
  logic [7:0]  rx_q [$];

  always @(negedge clk) begin
    if (rst) begin
      u_busy = 1'b0;
    end else if (!u_busy) begin
      if (!ser_tx && u_prev) begin
        u_busy = 1'b1; u_cnt = 0;
        if (!u_seen) begin u_seen = 1'b1; first_start = cyc; end
      end
    end else begin
      u_cnt++;
      if (u_cnt >= BAUD / 2 && (u_cnt - BAUD / 2) % BAUD == 0) begin
        int n;
        n = int'((u_cnt - BAUD / 2) / BAUD);
        if (n == 0) begin
          if (ser_tx) frame_err++;
        end else if (n <= 8) begin
          u_byte[n - 1] = ser_tx;
        end else begin
          if (!ser_tx) frame_err++;
          rx_q.push_back(u_byte);
          u_busy = 1'b0;
        end
      end
    end
    u_prev = ser_tx;
  end

  task automatic clear_mon();
    tr_cmd.delete(); tr_addr.delete(); tr_bits.delete(); tr_cyc.delete(); tr_gap.delete();
    rx_q.delete(); u_seen = 1'b0; frame_err = 0;
  endtask

  task automatic fill_mem_random();
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
  endtask

  task automatic wait_done(output int unsigned done_cyc);
    int unsigned k;
    k = 0;
    while (ledg_n !== 1'b0 && k < 5000) begin @(negedge clk); k++; end
    check("done_reached", {31'd0, ledg_n}, 32'd0);
    done_cyc = cyc;
  endtask

  // Compare the recorded traffic against what the flash contents imply.
  task automatic check_run(input string tag, input int unsigned done_cyc);
    check({tag, "_ntrans"}, tr_cmd.size(), 2);
    if (tr_cmd.size() >= 2) begin
      check({tag, "_wake_cmd"}, tr_cmd[0], 8'hAB);
      check({tag, "_wake_bits"}, tr_bits[0], 8);
      check({tag, "_wake_cyc"}, tr_cyc[0], 16);
      check({tag, "_read_cmd"}, tr_cmd[1], 8'h03);
      check({tag, "_read_addr"}, tr_addr[1], ADDR);
      check({tag, "_read_bits"}, tr_bits[1], 32 + 8 * NB);
      check({tag, "_read_cyc"}, tr_cyc[1], 2 * (32 + 8 * NB));
      check({tag, "_cs_gap"}, tr_gap[1] >= GAP, 1);
    end
    check({tag, "_nbytes"}, rx_q.size(), NB);
    for (int k = 0; k < NB && k < rx_q.size(); k++)
      check($sformatf("%s_byte%0d", tag, k), rx_q[k], mem[k]);
    check({tag, "_framing"}, frame_err, 0);
    check({tag, "_tx_cycles"}, done_cyc - first_start, BAUD * 10 * NB);
    check({tag, "_leds_done"}, {led1, led2, led3, ledg_n}, 4'b0010);
  endtask

  initial begin
    int unsigned dc, k;
    logic [1:0] v;
    mem = '{8'h1A, 8'h2B, 8'h3C, 8'h4D, 8'h5E, 8'h6F, 8'h00, 8'h00,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    // Reset state.
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_csb", flash_csb, 1'b1);
    check("rst_sclk", flash_clk, 1'b0);
    check("rst_tx", ser_tx, 1'b1);
    check("rst_io23", {flash_io2, flash_io3}, 2'b11);
    check("rst_leds", {ledr_n, ledg_n, led1, led2, led3, led4, led5}, 7'b1100000);
    clear_mon();

    // Release: first SPI clock rise carries the MSB of 0xAB.
    rst = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (flash_clk !== 1'b1 && k < 10);
    check("first_rise_le3", k <= 3, 1);
    check("first_mosi", flash_io0, 1'b1);
    check("busy_led1", {led1, led2}, 2'b10);

    // Run 1: fixed pattern.
    wait_done(dc);
    check_run("run1", dc);

    // Accelerator status follows through the synchronizer.
    for (int i = 0; i < 6; i++) begin
      v = 2'($urandom_range(0, 3));
      ml_irq = v[0]; ml_err = v[1];
      repeat (3) @(negedge clk);
      check($sformatf("ml%0d_leds", i), {ledr_n, led5, led4}, {~v[1], v[1], v[0]});
    end

    // Run 2: held button restarts exactly once.
    fill_mem_random(); clear_mon();
    btn1 = 1'b1;
    k = 0;
    while (ledg_n !== 1'b1 && k < 10) begin @(negedge clk); k++; end
    check("btn_leave_done", ledg_n, 1'b1);
    wait_done(dc);
    repeat (150) @(negedge clk);
    check("btn_held_no_restart", {ledg_n, 27'd0, 4'(tr_cmd.size())}, {1'b0, 27'd0, 4'd2});
    check_run("run2", dc);
    btn1 = 1'b0;
    repeat (5) @(negedge clk);

    // Run 3: 10-cycle pulse restarts; a pulse during READ is ignored.
    fill_mem_random(); clear_mon();
    btn1 = 1'b1; repeat (10) @(negedge clk); btn1 = 1'b0;
    repeat (60) @(negedge clk);
    btn1 = 1'b1; repeat (10) @(negedge clk); btn1 = 1'b0;
    wait_done(dc);
    repeat (50) @(negedge clk);
    check_run("run3", dc);

    // Run 4: reset during the third UART byte.
    fill_mem_random(); clear_mon();
    btn1 = 1'b1; repeat (10) @(negedge clk); btn1 = 1'b0;
    k = 0;
    while (rx_q.size() < 2 && k < 3000) begin @(negedge clk); k++; end
    check("midtx_two_bytes", rx_q.size(), 2);
    k = 0;
    while (ser_tx !== 1'b0 && k < 20) begin @(negedge clk); k++; end
    check("midtx_start_bit", ser_tx, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midtx_tx_idle", ser_tx, 1'b1);
    check("midtx_csb", flash_csb, 1'b1);
    repeat (2) @(negedge clk);
    clear_mon();
    rst = 1'b0;
    wait_done(dc);
    check_run("run4", dc);

    check("static_pins", static_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
